shift_seq: RTL and testbench

Multi-cycle shift/rotate sequencer for the 16-bit datapath. It accepts an operand, a shift operation and a 0–15 bit shift amount, and builds the full shift from repeated 2-bit steps plus at most one 1-bit step. This keeps the shifter hardware at a single narrow stage and trades area for latency. It sits beside the ALU and is driven by the execute-stage control, which stalls on `busy`.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_step.sv | 25 ++
 rtl/shift_seq.sv | 117 +++++++++++
 tb/tb_shift_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings, state type and defaults for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int unsigned SHIFT_WIDTH = 16;
  localparam int unsigned SHIFT_AMT_W = 4;

  localparam logic [2:0] SH_ROL = 3'b000;
  localparam logic [2:0] SH_ROR = 3'b001;
  localparam logic [2:0] SH_SLL = 3'b010;
  localparam logic [2:0] SH_SRA = 3'b011;
  localparam logic [2:0] SH_SRL = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } shseq_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= SH_SRL;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single narrow shift stage: one 1-bit or 2-bit step of the selected operation.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  input  logic             dist2,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      SH_ROL: y = dist2 ? {a[WIDTH-3:0], a[WIDTH-1:WIDTH-2]} : {a[WIDTH-2:0], a[WIDTH-1]};
      SH_ROR: y = dist2 ? {a[1:0], a[WIDTH-1:2]} : {a[0], a[WIDTH-1:1]};
      SH_SLL: y = dist2 ? {a[WIDTH-3:0], 2'b00} : {a[WIDTH-2:0], 1'b0};
      SH_SRA: y = dist2 ? {{2{a[WIDTH-1]}}, a[WIDTH-1:2]} : {a[WIDTH-1], a[WIDTH-1:1]};
      SH_SRL: y = dist2 ? {2'b00, a[WIDTH-1:2]} : {1'b0, a[WIDTH-1:1]};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: builds an N-bit shift from 2-bit steps
// plus at most one 1-bit step, reusing a single shift_step stage.
module shift_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH,
  parameter int unsigned AMT_W = SHIFT_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out
);

  shseq_state_t     state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step_y;
  logic [AMT_W-1:0] rem_q, rem_d, rem_step;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;
  logic             dist2;
  logic             imm_done;

  assign dist2    = rem_q > AMT_W'(1);
  assign rem_step = dist2 ? rem_q - AMT_W'(2) : '0;
  // Illegal ops and zero distance skip SHIFT entirely.
  assign imm_done = !op_legal(op) || (amt == '0);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a    (acc_q),
    .op   (op_q),
    .dist2(dist2),
    .y    (step_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = imm_done ? StDone : StShift;
      StShift: if (rem_step == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // out/err are loaded on the edge entering DONE so they are valid with done.
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    op_d  = op_q;
    out_d = out_q;
    err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = in;
          rem_d = amt;
          op_d  = op;
          if (!op_legal(op)) begin
            err_d = 1'b1;
          end else if (amt == '0) begin
            out_d = in;
          end
        end
      end
      StShift: begin
        acc_d = step_y;
        rem_d = rem_step;
        if (rem_step == '0) out_d = step_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
      op_q  <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      op_q  <= op_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    ready = (state_q == StIdle);
    busy  = (state_q != StIdle);
    done  = (state_q == StDone);
    err   = err_q;
    out   = out_q;
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed and randomized checks of shift_seq against a single-shot arithmetic model.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic [2:0]  dop = '0;
  logic [3:0]  damt = '0;
  logic        ready, busy, done, err;
  logic [15:0] dout;

  int          total = 0;
  int          bad = 0;
  logic [15:0] last_out = '0;

  always #5 clk = ~clk;

  shift_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in   (din),
    .op   (dop),
    .amt  (damt),
    .ready(ready),
    .busy (busy),
    .done (done),
    .err  (err),
    .out  (dout)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Single-shot shift of the whole distance; illegal ops leave the previous result.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [2:0] o,
                                        input int m, input logic [15:0] prev);
    logic [31:0] t;
    case (o)
      3'd0: begin t = {a, a} << m; return t[31:16]; end
      3'd1: begin t = {a, a} >> m; return t[15:0]; end
      3'd2: return a << m;
      3'd3: return $signed(a) >>> m;
      3'd4: return a >> m;
      default: return prev;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input int m);
    if (o > 3'd4 || m == 0) return 1;
    return 1 + (m + 1) / 2;
  endfunction

  task automatic launch(input logic [15:0] a, input logic [2:0] o, input logic [3:0] m);
    @(negedge clk);
    chk("ready_before_start", ready, 1);
    chk("done_idle", done, 0);
    start = 1'b1;
    din   = a;
    dop   = o;
    damt  = m;
  endtask

  // Waits for done after a launch; with hold, start stays high and only in changes.
  task automatic finish_op(input bit hold, input logic [15:0] exp_out, input bit exp_err,
                           input int lat);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
      end else begin
        chk("busy_in_flight", busy, 1);
        chk("ready_in_flight", ready, 0);
      end
      din = 16'($urandom);
      if (!hold) begin
        start = 1'b0;
        dop   = 3'($urandom);
        damt  = 4'($urandom);
      end
    end
    chk("latency", cyc, lat);
    chk("out", dout, exp_out);
    chk("err", err, exp_err);
    if (!exp_err) last_out = exp_out;
  endtask

  task automatic run(input logic [15:0] a, input logic [2:0] o, input logic [3:0] m);
    logic [15:0] e;
    e = model(a, o, int'(m), last_out);
    launch(a, o, m);
    finish_op(0, e, o > 3'd4, latency(o, int'(m)));
  endtask

  initial begin
    #3;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out", dout, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    launch(16'h8001, 3'd0, 4'd1);
    finish_op(0, 16'h0003, 0, 2);
    launch(16'h1234, 3'd1, 4'd4);
    finish_op(0, 16'h4123, 0, 3);
    launch(16'hAAAA, 3'b110, 4'd5);
    finish_op(0, 16'h4123, 1, 1);
    launch(16'h0001, 3'd2, 4'd15);
    finish_op(0, 16'h8000, 0, 9);
    launch(16'h8000, 3'd3, 4'd15);
    finish_op(0, 16'hFFFF, 0, 9);
    launch(16'h8000, 3'd4, 4'd15);
    finish_op(0, 16'h0001, 0, 9);
    for (int o = 0; o < 5; o++) begin
      launch(16'hBEEF, 3'(o), 4'd0);
      finish_op(0, 16'hBEEF, 0, 1);
    end
    run(16'h8001, 3'd0, 4'd15);

    // start held high: only one capture, then a fresh capture right after done
    launch(16'h00FF, 3'd2, 4'd6);
    finish_op(1, model(16'h00FF, 3'd2, 6, last_out), 0, 4);
    @(negedge clk);
    chk("ready_after_hold", ready, 1);
    din = 16'h0003;
    finish_op(0, 16'h00C0, 0, 4);

    for (int i = 0; i < 40; i++) begin
      run(16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    // reset in the middle of a SHIFT discards the operation
    launch(16'hFFFF, 3'd4, 4'd9);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_shift_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", dout, 16'h0000);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_rst", done, 0);
    end
    rst_n = 1'b1;
    last_out = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    launch(16'h0001, 3'd0, 4'd2);
    finish_op(0, 16'h0004, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
